// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin two-requester arbiter for one single-port BRAM
// Define BRAM_ARB_FIXED_PRIO_EN to give requester 0 fixed priority on contention.
module bram_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     n_clr,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic                     s0_we,
  input  logic [ADDRESS_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0]    s0_wdata,
  output logic                     s0_rvalid,
  output logic [DATA_WIDTH-1:0]    s0_rdata,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  input  logic                     s1_we,
  input  logic [ADDRESS_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0]    s1_wdata,
  output logic                     s1_rvalid,
  output logic [DATA_WIDTH-1:0]    s1_rdata,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     mem_read_en,
  output logic                     mem_write_en,
  output logic                     mem_n_clr,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CLEAR} state_t;

  state_t state_q, state_d;
  logic   run;
  logic   grant0, grant1;

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_RUN;
      ST_RUN:   if (clr_req) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_RUN;
      default:  state_d = ST_INIT;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign busy      = !run;
  assign mem_n_clr = run;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (run) begin
      grant0 = s0_valid;
      grant1 = s1_valid && !s0_valid;
    end
  end
`else
  logic rr_ptr_q;

  // Pointer names the requester that wins the next contended cycle.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr)      rr_ptr_q <= 1'b0;
    else if (grant0) rr_ptr_q <= 1'b1;
    else if (grant1) rr_ptr_q <= 1'b0;
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (run) begin
      grant0 = s0_valid && (!s1_valid || !rr_ptr_q);
      grant1 = s1_valid && (!s0_valid ||  rr_ptr_q);
    end
  end
`endif

  assign s0_ready = grant0;
  assign s1_ready = grant1;

  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    if (grant0) begin
      mem_read_en  = !s0_we;
      mem_write_en = s0_we;
      mem_addr     = s0_addr;
      mem_data_in  = s0_wdata;
    end else if (grant1) begin
      mem_read_en  = !s1_we;
      mem_write_en = s1_we;
      mem_addr     = s1_addr;
      mem_data_in  = s1_wdata;
    end
  end

  // Read data is captured at the grant edge so rdata holds until the next return.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      s0_rvalid <= 1'b0;
      s1_rvalid <= 1'b0;
      s0_rdata  <= '0;
      s1_rdata  <= '0;
    end else begin
      s0_rvalid <= grant0 && !s0_we;
      s1_rvalid <= grant1 && !s1_we;
      if (grant0 && !s0_we) s0_rdata <= mem_data_out;
      if (grant1 && !s1_we) s1_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench for bram_port_arbiter with a behavioural BRAM
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        n_clr;
  logic        s0_valid, s0_ready, s0_we, s0_rvalid;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic        s1_valid, s1_ready, s1_we, s1_rvalid;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic        clr_req, busy, mem_read_en, mem_write_en, mem_n_clr;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] shadow [0:15];
  int          mstate;
  bit          mptr;
  logic [31:0] mon_exp;
  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .n_clr(n_clr),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_we(s0_we), .s0_addr(s0_addr),
    .s0_wdata(s0_wdata), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_we(s1_we), .s1_addr(s1_addr),
    .s1_wdata(s1_wdata), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata),
    .clr_req(clr_req), .busy(busy),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_n_clr(mem_n_clr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Behavioural BRAM: synchronous clear and write, combinational read.
  always @(posedge clk) begin
    if (!mem_n_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (mem_write_en) begin
      mem[mem_addr[3:0]] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_addr[3:0]];

  // Scoreboard consumer: every rvalid pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (n_clr) begin
      if (s0_rvalid) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL s0_unexpected_rvalid rdata=%h expected no return", s0_rdata);
        end else begin
          mon_exp = q0.pop_front();
          if (s0_rdata !== mon_exp) begin
            errors++; $display("FAIL s0_rdata got=%h exp=%h", s0_rdata, mon_exp);
          end
        end
      end
      if (s1_rvalid) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL s1_unexpected_rvalid rdata=%h expected no return", s1_rdata);
        end else begin
          mon_exp = q1.pop_front();
          if (s1_rdata !== mon_exp) begin
            errors++; $display("FAIL s1_rdata got=%h exp=%h", s1_rdata, mon_exp);
          end
        end
      end
    end
  end

  // Drives one cycle of stimulus and advances the reference model.
  task automatic step(input bit v0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit v1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                      input bit clr);
    bit g0, g1;
    @(negedge clk);
    s0_valid = v0; s0_we = we0; s0_addr = a0; s0_wdata = d0;
    s1_valid = v1; s1_we = we1; s1_addr = a1; s1_wdata = d1;
    clr_req = clr;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (mstate == 1) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
      g0 = v0;
      g1 = v1 && !v0;
`else
      g0 = v0 && (!v1 || !mptr);
      g1 = v1 && (!v0 || mptr);
`endif
    end
    if (g0) begin
      if (we0) shadow[a0[3:0]] = d0; else q0.push_back(shadow[a0[3:0]]);
      mptr = 1'b1;
    end
    if (g1) begin
      if (we1) shadow[a1[3:0]] = d1; else q1.push_back(shadow[a1[3:0]]);
      mptr = 1'b0;
    end
    case (mstate)
      0, 2: mstate = 1;
      default: if (clr) begin
        mstate = 2;
        for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
      end
    endcase
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    n_clr = 1'b0;
    s0_valid = 0; s0_we = 0; s0_addr = 0; s0_wdata = 0;
    s1_valid = 0; s1_we = 0; s1_addr = 0; s1_wdata = 0;
    clr_req = 0;
    mstate = 0; mptr = 1'b0;
    q0.delete(); q1.delete();
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 n_clr = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step(1, 0, 5, 0, 0, 0, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy got=%b exp=1", busy); end
    checks++; if (mem_n_clr !== 1'b0) begin errors++; $display("FAIL init_mem_n_clr got=%b exp=0", mem_n_clr); end
    checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL init_ready got=%b exp=0", s0_ready); end
    checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL init_read_en got=%b exp=0", mem_read_en); end
    step(1, 0, 5, 0, 0, 0, 0, 0, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy got=%b exp=0", busy); end
    checks++; if (mem_n_clr !== 1'b1) begin errors++; $display("FAIL run_mem_n_clr got=%b exp=1", mem_n_clr); end
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL run_ready got=%b exp=1", s0_ready); end
    checks++; if (mem_read_en !== 1'b1 || mem_addr !== 32'd5) begin
      errors++; $display("FAIL run_read_drive got=%b/%h exp=1/00000005", mem_read_en, mem_addr);
    end
    idle();
  endtask

  task automatic test_write_read();
    step(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got=%b exp=1", s0_ready); end
    checks++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin
      errors++; $display("FAIL wr_enables got=we%b re%b exp=we1 re0", mem_write_en, mem_read_en);
    end
    checks++; if (mem_addr !== 32'd3 || mem_data_in !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_bus got=%h/%h exp=00000003/deadbeef", mem_addr, mem_data_in);
    end
    step(0, 0, 0, 0, 1, 0, 3, 0, 0);
    checks++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin
      errors++; $display("FAIL rd_ready got=s0 %b s1 %b exp=s0 0 s1 1", s0_ready, s1_ready);
    end
    idle();
    checks++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || mem_addr !== 32'h0 || mem_data_in !== 32'h0) begin
      errors++; $display("FAIL nogrant_bus got=re%b we%b %h %h exp=all zero", mem_read_en, mem_write_en, mem_addr, mem_data_in);
    end
    checks++; if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_rvalid got=s0 %b s1 %b exp=s0 0 s1 1", s0_rvalid, s1_rvalid);
    end
    idle();
    checks++; if (s1_rvalid !== 1'b0 || s1_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_hold got=%b/%h exp=0/deadbeef", s1_rvalid, s1_rdata);
    end
  endtask

  task automatic test_round_robin();
    bit exp0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 3, 0, 1, 0, 5, 0, 0);
`ifdef BRAM_ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (i % 2 == 0);
`endif
      checks++; if (s0_ready !== exp0 || s1_ready !== !exp0) begin
        errors++; $display("FAIL rr_grant[%0d] got=s0 %b s1 %b exp=s0 %b s1 %b", i, s0_ready, s1_ready, exp0, !exp0);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1, 8 + i, 32'h100 + i, 0);
      checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready[%0d] got=%b exp=1", i, s1_ready); end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, 8 + i, 0, 0);
      checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready[%0d] got=%b exp=1", i, s1_ready); end
    end
    idle();
  endtask

  task automatic test_clear();
    step(0, 0, 0, 0, 1, 1, 7, 32'h12, 0);
    step(1, 0, 7, 0, 0, 0, 0, 0, 1);
    checks++; if (s0_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_req_grant got=ready %b busy %b exp=ready 1 busy 0", s0_ready, busy);
    end
    step(1, 0, 7, 0, 1, 0, 7, 0, 0);
    checks++; if (busy !== 1'b1 || mem_n_clr !== 1'b0) begin
      errors++; $display("FAIL clear_state got=busy %b n_clr %b exp=busy 1 n_clr 0", busy, mem_n_clr);
    end
    checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || mem_read_en !== 1'b0) begin
      errors++; $display("FAIL clear_grants got=%b%b re%b exp=00 re0", s0_ready, s1_ready, mem_read_en);
    end
    step(1, 0, 7, 0, 0, 0, 0, 0, 0);
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL post_clear_ready got=%b exp=1", s0_ready); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (busy !== (i % 2 == 1)) begin
        errors++; $display("FAIL clr_hold_busy[%0d] got=%b exp=%b", i, busy, (i % 2 == 1));
      end
    end
    idle();
    idle();
  endtask

  task automatic test_reset_mid_read();
    step(1, 1, 2, 32'hA5A50001, 0, 0, 0, 0, 0);
    step(1, 0, 2, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 2, 0, 0, 0, 0, 0, 0);
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL midrd_ready got=%b exp=1", s0_ready); end
    #2 n_clr = 1'b0;
    #1;
    checks++; if (s0_rvalid !== 1'b0 || s0_rdata !== 32'h0) begin
      errors++; $display("FAIL async_rst_read got=%b/%h exp=0/00000000", s0_rvalid, s0_rdata);
    end
    checks++; if (busy !== 1'b1 || mem_n_clr !== 1'b0 || s0_ready !== 1'b0) begin
      errors++; $display("FAIL async_rst_state got=busy %b n_clr %b ready %b exp=1 0 0", busy, mem_n_clr, s0_ready);
    end
    @(posedge clk);
    #1;
    checks++; if (s0_rvalid !== 1'b0) begin errors++; $display("FAIL async_rst_edge got=%b exp=0", s0_rvalid); end
    do_reset();
    idle();
    step(1, 0, 2, 0, 0, 0, 0, 0, 0);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    n_clr = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_clear();
    test_reset_mid_read();
    idle();
    checks++; if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d/%0d pending exp=0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester controller that shares one single-port BRAM (single-cycle write, combinational read) between two independent masters. It grants at most one access per cycle using round-robin arbitration and drives the memory's enables, address and write data. It registers read data back to the winning requester and sequences the memory's synchronous clear after reset and on demand.

## Interface
- ADDRESS_WIDTH, 32, width of requester and memory address buses
- DATA_WIDTH, 32, width of write/read data buses

- clk  in  1  system clock, all state on rising edge
- n_clr  in  1  asynchronous active-low reset
- s0_valid / s1_valid  in  1  requester 0/1 has an access pending
- s0_ready / s1_ready  out  1  access accepted this cycle (valid && ready)
- s0_we / s1_we  in  1  1 = write, 0 = read
- s0_addr / s1_addr  in  ADDRESS_WIDTH  access address
- s0_wdata / s1_wdata  in  DATA_WIDTH  write data
- s0_rvalid / s1_rvalid  out  1  one-cycle pulse, read data valid
- s0_rdata / s1_rdata  out  DATA_WIDTH  registered read data, held until next read return
- clr_req  in  1  request a full memory clear
- busy  out  1  controller in INIT or CLEAR, no grants
- mem_read_en  out  1  to memory read enable
- mem_write_en  out  1  to memory write enable
- mem_n_clr  out  1  to memory synchronous clear, active low
- mem_addr  out  ADDRESS_WIDTH  to memory address
- mem_data_in  out  DATA_WIDTH  to memory write data
- mem_data_out  in  DATA_WIDTH  from memory combinational read data

## Operation
- FSM states: INIT, RUN, CLEAR. Reset enters INIT.
- INIT lasts one cycle with mem_n_clr=0, then goes to RUN.
- RUN with clr_req=1 goes to CLEAR. CLEAR lasts one cycle with mem_n_clr=0, then goes to RUN. clr_req is ignored while in CLEAR, so holding it high alternates CLEAR/RUN.
- In RUN, grants are combinational from valids:
  - One valid: that requester wins.
  - Both valid: the requester indicated by rr_ptr wins.
- After any grant, rr_ptr points to the other requester. rr_ptr resets to 0.
- Winner's ready=1. Loser's ready=0 and it must hold valid and payload stable.
- Grant drives the memory:
  - mem_addr = winner addr, passed unmodified.
  - mem_data_in = winner wdata.
  - mem_write_en = winner we.
  - mem_read_en = !winner we.
- No grant: mem_read_en=0, mem_write_en=0, mem_addr=0, mem_data_in=0.
- Read grant: mem_data_out is captured into the winner's rdata at the clock edge, and its rvalid=1 the following cycle for exactly one cycle. Writes never produce rvalid.
- INIT/CLEAR: both readies=0, busy=1, memory enables 0. A request sampled in the same cycle as clr_req in RUN is still granted normally.
- Reset values: s*_ready=0, s*_rvalid=0, s*_rdata=0, busy=1, mem_n_clr=0 (INIT), rr_ptr=0.

## Timing
- Grant: zero-cycle, ready is combinational from valid and state. There is a valid→ready combinational path, so requesters must not derive valid from ready.
- Write completes at the edge ending the grant cycle.
- Read latency: 1 cycle from acceptance to rvalid.
- Throughput: one access per cycle aggregate. A sole requester may issue back-to-back every cycle.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Read accepted in the cycle before CLEAR still returns pre-clear data. Reads after CLEAR return 0.
- Asynchronous reset mid-operation drops pending rvalid immediately and returns to INIT. No partial handshake survives.

## Configuration
- BRAM_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins contention, and rr_ptr is not implemented.
  - Undefined: round-robin as above.

## Test plan
- Reset release: busy=1 and mem_n_clr=0 for one cycle, then busy=0 → readies follow valids. After reset, a read of addr 5 gives s0_rvalid with rdata=0.
- s0 writes 0xDEADBEEF to addr 3, next cycle s1 reads addr 3 → s1_rvalid one cycle later, s1_rdata=0xDEADBEEF, s0_rvalid stays 0.
- Both valid reads every cycle for 4 cycles → grants s0,s1,s0,s1, each rvalid one cycle after its grant. With BRAM_ARB_FIXED_PRIO_EN, s0 is granted all 4 cycles and s1 is starved.
- Write 0x12 to addr 7, pulse clr_req → one CLEAR cycle with readies=0 and busy=1. A read of addr 7 then returns 0.
- Read accepted, n_clr asserted before the return edge → s0_rvalid=0 and s0_rdata=0 immediately, FSM in INIT.
